jtag_debug_ocimem_engine: RTL

- Sysclk-side consumer of the JTAG debug module's decoded command strobes and 38-bit jdo word.
- Turns OCI-memory commands (set address / read, streaming read, write) into single-word transactions on a waitrequest-style master port to the CPU debug RAM.
- Returns MonDReg, monitor_ready and monitor_error, which feed back into the JTAG TCK-side scan chain.

---
 rtl/jtag_debug_ocimem_engine.sv | 120 ++++++++++++
 1 files changed

// File: rtl/jtag_debug_ocimem_engine.sv
// OCI debug-memory engine: JTAG command strobes to a waitrequest master.
// Optional: OCIMEM_TIMEOUT_EN abandons a transaction after TIMEOUT_CYCLES stalls.
module jtag_debug_ocimem_engine #(
  parameter int ADDR_W         = 9,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy,
  output logic              cmd_drop,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] mon_a;
  logic              any_strobe;

`ifdef OCIMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`endif

  assign any_strobe     = take_action_ocimem_a | take_no_action_ocimem_a
                        | take_action_ocimem_b;
  assign busy           = (state != IDLE);
  assign mem_address    = mon_a;
  assign mem_writedata  = MonDReg;
  assign mem_byteenable = 4'hF;

  // Command acceptance, transaction tracking and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mon_a         <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      cmd_drop      <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
`ifdef OCIMEM_TIMEOUT_EN
      tcnt          <= '0;
`endif
    end else begin
      cmd_drop <= 1'b0;
      case (state)
        IDLE: begin
`ifdef OCIMEM_TIMEOUT_EN
          tcnt <= '0;
`endif
          if (take_action_ocimem_b) begin
            MonDReg       <= jdo[34:3];
            state         <= WR;
            mem_write     <= 1'b1;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
          end else if (take_action_ocimem_a) begin
            mon_a         <= jdo[ADDR_W+16:17];
            monitor_error <= 1'b0;
            if (jdo[34]) begin
              state         <= RD;
              mem_read      <= 1'b1;
              monitor_ready <= 1'b0;
            end else begin
              monitor_ready <= 1'b1;
            end
          end else if (take_no_action_ocimem_a) begin
            state         <= RD;
            mem_read      <= 1'b1;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
          end
        end
        RD, WR: begin
          if (any_strobe) cmd_drop <= 1'b1;
          if (!mem_waitrequest) begin
            if (state == RD) MonDReg <= mem_readdata;
            mon_a         <= mon_a + 1'b1;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            state         <= IDLE;
            monitor_ready <= 1'b1;
          end
`ifdef OCIMEM_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            state         <= IDLE;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
